out_port_ctrl: RTL
==================

# out_port_ctrl

Sequencer for the CPU's 16-bit output register. It buffers words written by OUT instructions in a small FIFO and generates the `ld_outr` strobe and data that load the output register. It then presents each word to the external device with a valid/ack handshake, and stalls the CPU when the buffer is full. It sits between the CPU control unit/register file and `out_reg`, whose `ld_outr` and data inputs it drives.

## Interface
Parameters:
- `WIDTH`, 16, data word width (must match the output register)
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `clr`  in  1  synchronous flush of FIFO and handshake state
- `wr_en`  in  1  CPU OUT-instruction write request
- `wr_data`  in  WIDTH  word to output (register-file RA value)
- `stall`  out  1  CPU hold; combinational `wr_en & full`
- `ld_outr`  out  1  load strobe to the output register
- `outr_data`  out  WIDTH  data to the output register (FIFO head)
- `out_valid`  out  1  output register holds a word not yet acknowledged
- `out_ack`  in  1  external device consumed the current word
- `level`  out  $clog2(DEPTH)+1  number of words buffered in the FIFO

## Operation
- FIFO:
  - Push when `wr_en & !full & !clr`.
  - Pop when `state==LOAD & !clr`.
  - `full` = (`level==DEPTH`); `empty` = (`level==0`).
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `level` is updated +1/−1/0 each edge; a simultaneous push and pop leaves it unchanged.
- A write while full is not accepted. `stall` is high that cycle, and the CPU holds `wr_en`/`wr_data` until `stall` drops. A pop in the same cycle does not unblock that write; it is accepted the following cycle.
- FSM, 3 states:
  - IDLE: if `!empty` → LOAD, else stay.
  - LOAD: `ld_outr=1`, `outr_data`=head; pop the head. Always → VALID.
  - VALID: `out_valid=1`.
    - `out_ack & !empty` → LOAD.
    - `out_ack & empty` → IDLE.
    - Otherwise stay.
- `out_ack` is ignored outside VALID.
- `ld_outr` = (state==LOAD) & !clr. `outr_data` is always the FIFO head; it is don't-care when `ld_outr=0`.
- `out_valid` = (state==VALID), decoded from registered state.
- `clr` takes priority over everything:
  - Pointers and `level` go to 0 and the FSM goes to IDLE at the next edge.
  - A write in the same cycle is dropped, and `stall` is low that cycle.
  - The output register keeps its last value.

## Timing
- Reset values: state IDLE, pointers 0, `level`=0, `ld_outr`=0, `out_valid`=0, `stall`=0.
- Reset mid-operation discards buffered words and any pending handshake immediately (asynchronous).
- Latency from a write accepted in cycle 0 with the FIFO empty and the FSM in IDLE:
  - cycle 1: `level`=1
  - cycle 2: `ld_outr`=1
  - edge ending cycle 2: output register loads
  - cycle 3: `out_valid`=1
- Throughput with `out_ack` tied high: one word per 2 cycles (VALID→LOAD→VALID).
- The handshake completes on the edge where `out_valid & out_ack`. The output register value is stable for the whole of VALID.
- `stall` depends combinationally on `wr_en`. There is no path from `out_ack` to `stall`.

## Structure
- Package `out_port_pkg`:
  - state encoding: IDLE=2'b00, LOAD=2'b01, VALID=2'b10; 2'b11 recovers to IDLE
  - default WIDTH/DEPTH constants
- Sub-module `sync_fifo`: storage, pointers, `level`, `full`/`empty`. It has an asynchronous reset and a synchronous `clr`. The FSM and handshake logic live in `out_port_ctrl`.
- `out_reg` is instantiated outside this block, with `ld_outr`/`outr_data` wired to its `ld_outr`/`ra` inputs.

## Test plan
- Single word: write 16'hA5A5 with `out_ack`=0 → `ld_outr` pulses at cycle 2 with `outr_data`=16'hA5A5. `out_valid` rises at cycle 3 and holds. Ack at cycle 6 → `out_valid` drops at cycle 7 and the FSM is in IDLE.
- Fill: with `out_ack`=0, write 1,2,3,4,5,6 on back-to-back cycles:
  - word 1 moves to the output register, words 2–5 fill the FIFO (`level`=4)
  - `stall`=1 on the write of 6, which is held
  - one ack → 6 is accepted one cycle after the pop
  - words are delivered in order 1..6
- Streaming: `out_ack` tied high, 8 writes → 8 `ld_outr` pulses exactly 2 cycles apart, data in order, `level` never exceeds DEPTH.
- Flush: `level`=3 in VALID, `clr` with `wr_en` of 16'h0F0F → next cycle `level`=0, IDLE, `out_valid`=0; 16'h0F0F is never loaded.
- Async reset: assert `rst` mid-LOAD, off the clock edge → `ld_outr`, `out_valid`, `level` go to 0 immediately. After release, a fresh write follows the nominal 3-cycle latency.

Source files
------------

// File: rtl/out_port_pkg.sv
// Shared types and default sizing for the output-port sequencer.
package out_port_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 4;

  // 2'b11 is unused and recovers to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_VALID = 2'b10
  } state_t;

endpackage

// File: rtl/out_port_ctrl_sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers, occupancy level and flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & ~empty & ~clr;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and level; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/out_port_ctrl.sv
// Output-port sequencer: buffers OUT writes, loads the output register and
// runs the valid/ack handshake to the external device.
module out_port_ctrl
  import out_port_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   stall,
  output logic                   ld_outr,
  output logic [WIDTH-1:0]       outr_data,
  output logic                   out_valid,
  input  logic                   out_ack,
  output logic [$clog2(DEPTH):0] level
);

  state_t state;
  state_t state_nxt;
  logic   full;
  logic   empty;
  logic   push;

  // A write blocked by a full FIFO stalls the CPU; clr drops the write instead
  assign push  = wr_en & ~full & ~clr;
  assign stall = wr_en & full & ~clr;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .push    (push),
    .pop     (ld_outr),
    .wr_data (wr_data),
    .rd_data (outr_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and strobes decoded from the registered state
  always_comb begin
    state_nxt = state;
    ld_outr   = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ld_outr   = ~clr;
        state_nxt = ST_VALID;
      end
      ST_VALID: begin
        out_valid = 1'b1;
        if (out_ack) begin
          state_nxt = empty ? ST_IDLE : ST_LOAD;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (clr) begin
      state_nxt = ST_IDLE;
    end
  end

endmodule
